// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Build option RAM_ARB_FIXED_PRIO_EN (see rr_arb2) is not referenced here.
package ram_arb_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 1;

  // Requester encoding; also the encoding of the LAST pointer.
  localparam logic REQ_IDX_A = 1'b0;
  localparam logic REQ_IDX_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/ram_2x8_arbiter_if.sv
// Client-side bus of the RAM arbiter: both request channels, acks, read data, busy.
// The build option RAM_ARB_FIXED_PRIO_EN does not change this interface.
interface ram_2x8_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
);

  logic          REQ_A;
  logic          REQ_B;
  logic          WE_A;
  logic          WE_B;
  logic [AW-1:0] ADDR_A;
  logic [AW-1:0] ADDR_B;
  logic [DW-1:0] WDATA_A;
  logic [DW-1:0] WDATA_B;
  logic          ACK_A;
  logic          ACK_B;
  logic [DW-1:0] RDATA;
  logic          BUSY;

  // Client side drives requests.
  modport master (
    output REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B,
    input  ACK_A, ACK_B, RDATA, BUSY
  );

  // Arbiter side answers them.
  modport slave (
    input  REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B,
    output ACK_A, ACK_B, RDATA, BUSY
  );

endinterface

// File: rtl/RAM_2x8.sv
// Behavioural 2-word RAM: synchronous write when R_W_ is high, combinational read.
// Unaffected by RAM_ARB_FIXED_PRIO_EN; contents survive arbiter reset.
module RAM_2x8 #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 1
) (
  input  logic          CLK_,
  input  logic          R_W_,
  input  logic [AW-1:0] ADDR_,
  input  logic [DW-1:0] DATA_IN,
  output logic [DW-1:0] DATA_OUT
);

  logic [DW-1:0] mem_q [2**AW];

  // Write port.
  always_ff @(posedge CLK_) begin
    if (R_W_) begin
      mem_q[ADDR_] <= DATA_IN;
    end
  end

  assign DATA_OUT = mem_q[ADDR_];

endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way grant.
// Default: round-robin on a one-bit LAST pointer (tie goes to the requester != LAST).
// RAM_ARB_FIXED_PRIO_EN defined: A always beats B and no LAST input exists.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic last_i,
`endif
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  // Pick a winner whenever at least one request is present.
  always_comb begin
    gnt_valid_o = req_a_i | req_b_i;
    gnt_idx_o   = REQ_IDX_A;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (!req_a_i && req_b_i) begin
      gnt_idx_o = REQ_IDX_B;
    end
`else
    if (req_a_i && req_b_i) begin
      gnt_idx_o = (last_i == REQ_IDX_A) ? REQ_IDX_B : REQ_IDX_A;
    end else if (req_b_i) begin
      gnt_idx_o = REQ_IDX_B;
    end
`endif
  end

endmodule

// File: rtl/ram_2x8_arbiter.sv
// Two-requester access controller for RAM_2x8: IDLE -> ACCESS -> RESP per transaction.
// All RAM pins and ACKs come straight from flops.
// RAM_ARB_FIXED_PRIO_EN defined: fixed A-over-B priority, no LAST register.
module ram_2x8_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic                   CLK_,
  input  logic                   CLR_,
  ram_2x8_arbiter_if.slave       bus,
  output logic                   RAM_R_W_,
  output logic [AW-1:0]          RAM_ADDR_,
  output logic [DW-1:0]          RAM_DATA_IN,
  input  logic [DW-1:0]          RAM_DATA_OUT
);

  state_e        state_q, state_d;
  logic          idx_q, idx_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rw_q, rw_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          gnt_valid, gnt_idx;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic          last_q, last_d;
`endif

  rr_arb2 u_arb (
    .req_a_i     (bus.REQ_A),
    .req_b_i     (bus.REQ_B),
`ifndef RAM_ARB_FIXED_PRIO_EN
    .last_i      (last_q),
`endif
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Next-state, field latching and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = 1'b0;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          idx_d = gnt_idx;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_d = gnt_idx;
`endif
          if (gnt_idx == REQ_IDX_A) begin
            we_d    = bus.WE_A;
            addr_d  = bus.ADDR_A;
            wdata_d = bus.WDATA_A;
          end else begin
            we_d    = bus.WE_B;
            addr_d  = bus.ADDR_B;
            wdata_d = bus.WDATA_B;
          end
          // R_W_ is valid for exactly the ACCESS cycle.
          rw_d    = we_d;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = RAM_DATA_OUT;
        end
        ack_a_d = (idx_q == REQ_IDX_A);
        ack_b_d = (idx_q == REQ_IDX_B);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge CLK_ or posedge CLR_) begin
    if (CLR_) begin
      state_q <= IDLE;
      idx_q   <= REQ_IDX_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q  <= REQ_IDX_B;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign RAM_R_W_    = rw_q;
  assign RAM_ADDR_   = addr_q;
  assign RAM_DATA_IN = wdata_q;
  assign bus.ACK_A   = ack_a_q;
  assign bus.ACK_B   = ack_b_q;
  assign bus.RDATA   = rdata_q;
  assign bus.BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_ram_2x8_arbiter.sv
// Self-checking bench for ram_2x8_arbiter with a RAM_2x8 behind it.
// Scoreboard: expected ack results queued per requester at stimulus time.
// Define RAM_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_ram_2x8_arbiter;

  typedef struct {
    bit         rd;
    logic [7:0] data;
  } sb_t;

  logic       clk;
  logic       clr;
  logic       ram_rw;
  logic [0:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  ram_2x8_arbiter_if #(.DW(8), .AW(1)) bus ();

  ram_2x8_arbiter #(.DW(8), .AW(1)) dut (
    .CLK_         (clk),
    .CLR_         (clr),
    .bus          (bus),
    .RAM_R_W_     (ram_rw),
    .RAM_ADDR_    (ram_addr),
    .RAM_DATA_IN  (ram_din),
    .RAM_DATA_OUT (ram_dout)
  );

  RAM_2x8 #(.DW(8), .AW(1)) u_ram (
    .CLK_     (clk),
    .R_W_     (ram_rw),
    .ADDR_    (ram_addr),
    .DATA_IN  (ram_din),
    .DATA_OUT (ram_dout)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  int         prev_ack = -1;
  bit         chk_space = 0;
  logic [7:0] last_rd = 8'h00;
  logic [7:0] shadow [2];
  sb_t        exp_a [$];
  sb_t        exp_b [$];
  bit         exp_grant [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one request, wait (bounded) for its ack, release on the ack edge.
  task automatic issue(input bit idx, input bit we, input logic [0:0] addr,
                       input logic [7:0] d, input bit chk_lat);
    int c0;
    bit got;
    sb_t e;
    @(negedge clk);
    e.rd   = !we;
    e.data = we ? 8'h00 : shadow[addr];
    if (we) shadow[addr] = d;
    if (idx == 1'b0) begin
      exp_a.push_back(e);
      bus.WE_A = we; bus.ADDR_A = addr; bus.WDATA_A = d; bus.REQ_A = 1'b1;
    end else begin
      exp_b.push_back(e);
      bus.WE_B = we; bus.ADDR_B = addr; bus.WDATA_B = d; bus.REQ_B = 1'b1;
    end
    c0  = cyc;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((idx == 1'b0 && bus.ACK_A) || (idx == 1'b1 && bus.ACK_B)) got = 1;
    end
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    else if (chk_lat) check_eq("ack_latency", cyc - c0, 32'd2);
    @(posedge clk);
    #1;
    if (idx == 1'b0) bus.REQ_A = 1'b0;
    else bus.REQ_B = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    last_rd = 8'h00;
  endtask

  // Monitor: pops the scoreboard on every ack.
  initial begin
    sb_t e;
    bit  who;
    forever begin
      @(negedge clk);
      if (bus.ACK_A || bus.ACK_B) begin
        check_eq("dual_ack", {31'd0, bus.ACK_A & bus.ACK_B}, 32'd0);
        who = bus.ACK_B;
        if (exp_grant.size() > 0) check_eq("grant_order", {31'd0, who}, {31'd0, exp_grant.pop_front()});
        if (chk_space) begin
          if (prev_ack >= 0) check_eq("ack_spacing", cyc - prev_ack, 32'd3);
          prev_ack = cyc;
        end
        if ((who == 1'b0 && exp_a.size() == 0) || (who == 1'b1 && exp_b.size() == 0)) begin
          check_eq("spurious_ack", 32'd1, 32'd0);
        end else begin
          e = (who == 1'b0) ? exp_a.pop_front() : exp_b.pop_front();
          if (e.rd) begin
            check_eq("rdata", {24'd0, bus.RDATA}, {24'd0, e.data});
            last_rd = e.data;
          end else begin
            check_eq("rdata_hold", {24'd0, bus.RDATA}, {24'd0, last_rd});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.REQ_A = 0; bus.REQ_B = 0; bus.WE_A = 0; bus.WE_B = 0;
    bus.ADDR_A = '0; bus.ADDR_B = '0; bus.WDATA_A = '0; bus.WDATA_B = '0;
    shadow[0] = 8'h00; shadow[1] = 8'h00;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rw",    {31'd0, ram_rw}, 32'd0);
    check_eq("rst_addr",  {31'd0, ram_addr}, 32'd0);
    check_eq("rst_din",   {24'd0, ram_din}, 32'd0);
    check_eq("rst_rdata", {24'd0, bus.RDATA}, 32'd0);
    check_eq("rst_acks",  {30'd0, bus.ACK_A, bus.ACK_B}, 32'd0);
    check_eq("rst_busy",  {31'd0, bus.BUSY}, 32'd0);
    clr = 1'b0;

    // Single write then read.
    issue(1'b0, 1'b1, 1'b0, 8'hAA, 1'b1);
    issue(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Isolation between words.
    issue(1'b1, 1'b1, 1'b1, 8'hCC, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    issue(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous writes from reset: A first, then B.
    do_reset();
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    fork
      issue(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
      issue(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
    join
    shadow[0] = 8'h22;
    check_eq("grants_consumed", exp_grant.size(), 32'd0);
    issue(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Sustained contention with both requesters held high (reads).
    do_reset();
    @(negedge clk);
    prev_ack  = -1;
    chk_space = 1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(1'b0);
      exp_a.push_back('{rd: 1'b1, data: shadow[0]});
    end
    exp_grant.push_back(1'b1);
    exp_b.push_back('{rd: 1'b1, data: shadow[1]});
    bus.WE_A = 0; bus.ADDR_A = 1'b0; bus.REQ_A = 1;
    bus.WE_B = 0; bus.ADDR_B = 1'b1; bus.REQ_B = 1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (bus.ACK_A || bus.ACK_B) n++;
    end
    bus.REQ_A = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      @(negedge clk);
      if (bus.ACK_A || bus.ACK_B) n++;
    end
    bus.REQ_B = 0;
    check_eq("contention_acks", n, 32'd5);
`else
    for (int i = 0; i < 3; i++) begin
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
      exp_a.push_back('{rd: 1'b1, data: shadow[0]});
      exp_b.push_back('{rd: 1'b1, data: shadow[1]});
    end
    bus.WE_A = 0; bus.ADDR_A = 1'b0; bus.REQ_A = 1;
    bus.WE_B = 0; bus.ADDR_B = 1'b1; bus.REQ_B = 1;
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (bus.ACK_A || bus.ACK_B) n++;
    end
    bus.REQ_A = 0;
    bus.REQ_B = 0;
    check_eq("contention_acks", n, 32'd6);
`endif
    chk_space = 0;
    repeat (4) @(negedge clk);
    check_eq("contention_drained", exp_a.size() + exp_b.size(), 32'd0);

    // Reset during the ACCESS cycle of an A write: aborted, no ack.
    @(negedge clk);
    bus.WE_A = 1; bus.ADDR_A = 1'b0; bus.WDATA_A = 8'h55; bus.REQ_A = 1;
    @(posedge clk);
    #1;
    check_eq("mid_rw_before", {31'd0, ram_rw}, 32'd1);
    #1;
    clr = 1'b1;
    #1;
    check_eq("mid_rw_after", {31'd0, ram_rw}, 32'd0);
    check_eq("mid_busy",     {31'd0, bus.BUSY}, 32'd0);
    check_eq("mid_addr",     {31'd0, ram_addr}, 32'd0);
    check_eq("mid_rdata",    {24'd0, bus.RDATA}, 32'd0);
    bus.REQ_A = 0;
    last_rd = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("mid_no_ack", {30'd0, bus.ACK_A, bus.ACK_B}, 32'd0);
    clr = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", exp_a.size() + exp_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_2x8_arbiter.md
# ram_2x8_arbiter

Two-requester access controller for the 2-word × 8-bit RAM (`RAM_2x8`).
- Arbitrates between requester A and requester B.
- Sequences each granted request into one RAM write or read.
- Drives the RAM's `R_W_`, `ADDR_` and `DATA_IN` pins and returns read data with a one-cycle acknowledge.
- Sits between the RAM instance and the two client blocks; it is the only driver of the RAM control pins.

## Interface
Parameters:
- `DW`, 8, data width; must match the RAM word width.
- `AW`, 1, address width; 2 words.

Ports:
- `CLK_` in 1: single clock, rising-edge active.
- `CLR_` in 1: asynchronous, active-high reset.
- `REQ_A`, `REQ_B` in 1: request; held high with its fields stable until the matching ACK.
- `WE_A`, `WE_B` in 1: 1 = write, 0 = read.
- `ADDR_A`, `ADDR_B` in AW: word address.
- `WDATA_A`, `WDATA_B` in DW: write data.
- `ACK_A`, `ACK_B` out 1: one-cycle completion pulse.
- `RDATA` out DW: read data; valid while the ACK is high and held until the next read completes.
- `BUSY` out 1: high in ACCESS and RESP.
- `RAM_R_W_` out 1, `RAM_ADDR_` out AW, `RAM_DATA_IN` out DW: go to the RAM.
- `RAM_DATA_OUT` in DW: combinational read port of the RAM.

## Operation
- FSM states:
  - IDLE
    - If any REQ is high: pick the winner, latch its WE, ADDR and WDATA, and go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS (1 cycle)
    - `RAM_R_W_` = latched WE; `RAM_ADDR_` and `RAM_DATA_IN` = latched fields.
    - A write commits at the closing edge.
    - A read captures `RAM_DATA_OUT` into `RDATA` at the closing edge.
    - Go to RESP.
  - RESP (1 cycle)
    - `RAM_R_W_` = 0; the winner's ACK = 1.
    - Always go to IDLE; no direct RESP→ACCESS path.
- Arbitration:
  - Round-robin over a one-bit `LAST` pointer.
  - If only one requester is high, it wins.
  - If both are high, the requester not equal to `LAST` wins.
  - `LAST` updates on entry to ACCESS.
- A write does not update `RDATA`.
- All RAM-side and ACK outputs are registered; there is no combinational path from REQ to the RAM pins.
- A REQ that drops before it is granted is ignored; there is no error.

## Timing
- Reset values:
  - State IDLE, `LAST` = B (A wins the first tie).
  - `RAM_R_W_` = 0, `RAM_ADDR_` = 0, `RAM_DATA_IN` = 0.
  - `RDATA` = 0, ACKs = 0, `BUSY` = 0.
- Latency:
  - REQ sampled high at edge N (in IDLE).
  - RAM operation during cycle N→N+1.
  - ACK high during N+1→N+2.
  - IDLE during N+2→N+3.
- Throughput: one transaction per 3 cycles.
  - With both requesters held high, grants alternate A, B, A, …
- The requester deasserts REQ on the edge where it samples ACK = 1. That REQ is therefore low when IDLE samples it, so a completed request is never re-served.
- `CLR_` asserted mid-ACCESS:
  - All outputs go to their reset values immediately (`RAM_R_W_` drops asynchronously).
  - A write not yet clocked is aborted and no ACK is issued.
  - The requester must re-request.
- `CLR_` released: the first arbitration happens at the first rising edge with `CLR_` low.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, A always beats B.
  - `LAST` is not implemented.
  - B can starve.
- Not defined: round-robin as described above (default).

## Structure
- Shared package `ram_arb_pkg`:
  - State enum `IDLE`/`ACCESS`/`RESP`.
  - Requester index constants `REQ_IDX_A`/`REQ_IDX_B`.
  - Default `DW`/`AW`.
- Sub-module `rr_arb2`:
  - Combinational 2-way grant from the two REQs and `LAST`.
  - Carries the `RAM_ARB_FIXED_PRIO_EN` switch.
- The top level holds the FSM, the field latches and `RDATA`.
- The bench instantiates `RAM_2x8` behind this block.

## Test plan
- Single write then read:
  - A writes 0xAA to addr 0 → ACK_A 2 cycles after the request edge.
  - A then reads addr 0 → `RDATA` = 0xAA while ACK_A is high.
- Isolation:
  - B writes 0xCC to addr 1.
  - A reads addr 1 → 0xCC; A reads addr 0 → 0xAA, unchanged.
- Simultaneous requests from reset:
  - Both requesters high with write 0x11 (A) and 0x22 (B) to addr 0.
  - A is served first, then B.
  - A final read of addr 0 → 0x22.
- Sustained contention:
  - Both held high for 6 transactions → grants A,B,A,B,A,B at a 3-cycle spacing.
  - Never two ACKs in the same cycle.
- Reset mid-ACCESS:
  - Assert `CLR_` during an A write of 0x55 before the edge → no ACK, `RAM_R_W_` = 0 at once.
  - Address keeps its old value on a later read.
- Fixed-priority build (`RAM_ARB_FIXED_PRIO_EN`):
  - Both held high for 4 transactions → all 4 grants go to A; B is served only after A drops.
